// File: rtl/controle_escala.sv
// ---------------------------------------------------------------------------
// controle_escala
//   Command sequencer for the downscaling engines of the coprocessor ULA.
//   Takes one command (engine slot + scale factor) at a time, validates it,
//   holds every engine slot in reset, then releases only the selected slot.
//   While that slot runs, its ROM-read and RAM-write buses are muxed onto
//   the shared frame memories. On completion, timeout or abort the slot is
//   parked in reset again and a status code is reported.
//
// Ports
//   clk, reset         clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only while not busy)
//   cmd_op, cmd_fator  engine slot index, scale factor
//   cmd_abort          level abort, honoured in ARM and RUN
//   fator_out          latched factor broadcast to all engines
//   eng_rst_n          per-slot active-low engine reset
//   eng_rom_addr/
//   eng_wraddr/
//   eng_pixel/eng_done per-slot engine buses (slot i in lane i)
//   mem_*              shared ROM address and RAM write port
//   busy, done, erro   status (erro: 0 ok, 1 op, 2 fator, 3 timeout, 4 abort)
// ---------------------------------------------------------------------------
module controle_escala #(
    parameter logic [3:0] ENG_MASK  = 4'b1111,
    parameter logic [7:0] FATOR_OK  = 8'b0001_0100,
    parameter int         SETUP_CYC = 2,
    parameter int         TIMEOUT   = 200000,
    parameter int         AW        = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [2:0]      cmd_fator,
    input  logic            cmd_abort,
    output logic [2:0]      fator_out,
    output logic [3:0]      eng_rst_n,
    input  logic [4*AW-1:0] eng_rom_addr,
    input  logic [4*AW-1:0] eng_wraddr,
    input  logic [4*8-1:0]  eng_pixel,
    input  logic [3:0]      eng_done,
    output logic [AW-1:0]   mem_rom_addr,
    output logic [AW-1:0]   mem_wraddr,
    output logic [7:0]      mem_wrdata,
    output logic            mem_we,
    output logic            busy,
    output logic            done,
    output logic [2:0]      erro
);

    localparam int NUM_SLOTS = 4;
    // One counter serves both the ARM setup wait and the RUN timeout.
    localparam int CNT_MAX   = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_OP    = 3'd1;
    localparam logic [2:0] E_FATOR = 3'd2;
    localparam logic [2:0] E_TMO   = 3'd3;
    localparam logic [2:0] E_ABORT = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIM   = 3'd4,
        ERRO  = 3'd5
    } estado_t;

    estado_t        estado, estado_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     sel, sel_n;
    logic [2:0]     fator_q, fator_n;
    logic           done_q, done_n;
    logic [2:0]     erro_q, erro_n;
    logic [3:0]     rst_n_q, rst_n_n;

    // Per-slot views of the flattened engine buses.
    logic [NUM_SLOTS-1:0][AW-1:0] rom_v;
    logic [NUM_SLOTS-1:0][AW-1:0] wra_v;
    logic [NUM_SLOTS-1:0][7:0]    pix_v;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign rom_v[g] = eng_rom_addr[g*AW +: AW];
        assign wra_v[g] = eng_wraddr[g*AW +: AW];
        assign pix_v[g] = eng_pixel[g*8 +: 8];
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado  <= IDLE;
            cnt     <= '0;
            sel     <= 2'd0;
            fator_q <= 3'd0;
            done_q  <= 1'b0;
            erro_q  <= E_NONE;
            rst_n_q <= 4'b0000;
        end else begin
            estado  <= estado_n;
            cnt     <= cnt_n;
            sel     <= sel_n;
            fator_q <= fator_n;
            done_q  <= done_n;
            erro_q  <= erro_n;
            rst_n_q <= rst_n_n;
        end
    end

    // ----------------------------------------------------- next-state logic
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        sel_n    = sel;
        fator_n  = fator_q;
        done_n   = done_q;
        erro_n   = erro_q;

        unique case (estado)
            IDLE, FIM, ERRO: begin
                if (cmd_valid) begin
                    done_n  = 1'b0;
                    erro_n  = E_NONE;
                    sel_n   = cmd_op;
                    fator_n = cmd_fator;
                    cnt_n   = '0;
                    if (!ENG_MASK[cmd_op]) begin
                        erro_n   = E_OP;
                        estado_n = ERRO;
                    end else if (cmd_fator == 3'd0 || !FATOR_OK[cmd_fator]) begin
                        erro_n   = E_FATOR;
                        estado_n = ERRO;
                    end else begin
                        estado_n = ARM;
                    end
                end
            end

            ARM: begin
                if (cmd_abort) begin
                    erro_n   = E_ABORT;
                    estado_n = ERRO;
                end else if (cnt == CW'(SETUP_CYC - 1)) begin
                    cnt_n    = '0;
                    estado_n = RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            RUN: begin
                cnt_n = cnt + CW'(1);
                if (cmd_abort) begin
                    erro_n   = E_ABORT;
                    estado_n = ERRO;
                end else if (eng_done[sel]) begin
                    estado_n = DRAIN;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    erro_n   = E_TMO;
                    estado_n = ERRO;
                end
            end

            // One extra write cycle so the pixel registered alongside done
            // still reaches memory; done becomes visible on entering FIM.
            DRAIN: begin
                done_n   = 1'b1;
                estado_n = FIM;
            end

            default: estado_n = IDLE;
        endcase
    end

    // Engine resets are registered from the next state so the reset lines
    // never glitch while the state register changes encoding.
    always_comb begin
        rst_n_n = 4'b0000;
        if (estado_n == RUN || estado_n == DRAIN)
            rst_n_n = 4'b0001 << sel_n;
    end

    // -------------------------------------------------------------- outputs
    logic liberado;

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        liberado  = 1'b0;
        unique case (estado)
            IDLE, FIM, ERRO: cmd_ready = 1'b1;
            ARM:             busy      = 1'b1;
            RUN, DRAIN: begin
                busy     = 1'b1;
                liberado = 1'b1;
            end
            default: ;
        endcase
    end

    // The selected engine keeps address/data stable between its writes, so
    // holding mem_we high for the whole run only rewrites the same pixel.
    always_comb begin
        mem_rom_addr = '0;
        mem_wraddr   = '0;
        mem_wrdata   = 8'd0;
        mem_we       = 1'b0;
        if (liberado) begin
            mem_rom_addr = rom_v[sel];
            mem_wraddr   = wra_v[sel];
            mem_wrdata   = pix_v[sel];
            mem_we       = 1'b1;
        end
    end

    assign eng_rst_n = rst_n_q;
    assign fator_out = fator_q;
    assign done      = done_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_controle_escala.sv
// ---------------------------------------------------------------------------
// tb_controle_escala
//   Drives commands into controle_escala with four stub engines and checks
//   each command against an outcome model: which status code results, how
//   many cycles the selected slot stays released, and that only that slot's
//   buses reach the shared memory port.
// ---------------------------------------------------------------------------
module tb_controle_escala;

    localparam logic [3:0] MASK  = 4'b0111;   // slot 3 unpopulated
    localparam logic [7:0] OK    = 8'b0001_0100;
    localparam int         SETUP = 2;
    localparam int         TMO   = 120;
    localparam int         AW    = 19;
    localparam int         NO_AB = 100000;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'd0;
    logic [2:0]      cmd_fator = 3'd0;
    logic            cmd_abort = 1'b0;
    logic [2:0]      fator_out;
    logic [3:0]      eng_rst_n;
    logic [4*AW-1:0] eng_rom_addr;
    logic [4*AW-1:0] eng_wraddr;
    logic [4*8-1:0]  eng_pixel;
    logic [3:0]      eng_done;
    logic [AW-1:0]   mem_rom_addr;
    logic [AW-1:0]   mem_wraddr;
    logic [7:0]      mem_wrdata;
    logic            mem_we;
    logic            busy;
    logic            done;
    logic [2:0]      erro;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controle_escala #(
        .ENG_MASK (MASK),
        .FATOR_OK (OK),
        .SETUP_CYC(SETUP),
        .TIMEOUT  (TMO),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_fator   (cmd_fator),
        .cmd_abort   (cmd_abort),
        .fator_out   (fator_out),
        .eng_rst_n   (eng_rst_n),
        .eng_rom_addr(eng_rom_addr),
        .eng_wraddr  (eng_wraddr),
        .eng_pixel   (eng_pixel),
        .eng_done    (eng_done),
        .mem_rom_addr(mem_rom_addr),
        .mem_wraddr  (mem_wraddr),
        .mem_wrdata  (mem_wrdata),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .erro        (erro)
    );

    // Stub engines: free-running counter while released, cleared in reset.
    // done is NOT gated by reset, so unselected slots with dat=0 shout done
    // permanently and must be ignored by the sequencer.
    logic [15:0]  scnt [4];
    int unsigned  dat  [4];

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            scnt[i] <= eng_rst_n[i] ? scnt[i] + 16'd1 : 16'd0;

    for (genvar g = 0; g < 4; g++) begin : g_stub
        assign eng_rom_addr[g*AW +: AW] = {3'(g), scnt[g]};
        assign eng_wraddr[g*AW +: AW]   = {3'(g), ~scnt[g]};
        assign eng_pixel[g*8 +: 8]      = scnt[g][7:0] ^ 8'(g*37 + 1);
        assign eng_done[g]              = 32'(scnt[g]) >= dat[g];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ab: RUN cycle (0 = first released cycle) in which abort is raised,
    //     -1 = first ARM cycle, NO_AB = never.
    task automatic run_cmd(input int op, input int fator, input int d, input int ab);
        int e, run_len, drain, exp_arm, rel_idx;
        int busy_c, we_c, rel_c, arm_c, bad_rst, bad_mux;
        bit fim;
        logic [3:0] oh;

        // outcome model
        oh = 4'b0001 << op;
        run_len = 0; drain = 0; exp_arm = 0;
        if (!MASK[op])                    e = 1;
        else if (fator == 0 || !OK[fator]) e = 2;
        else if (ab < 0) begin e = 4; exp_arm = 1; end
        else begin
            exp_arm = SETUP;
            if (ab <= d && ab <= TMO - 1) begin e = 4; run_len = ab + 1; end
            else if (d <= TMO - 1)        begin e = 0; run_len = d + 1; drain = 1; end
            else                          begin e = 3; run_len = TMO; end
        end

        for (int i = 0; i < 4; i++) dat[i] = 0;
        dat[op] = d;

        cmd_op = 2'(op); cmd_fator = 3'(fator); cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ready_after_accept", cmd_ready, (e == 1 || e == 2));
        chk("erro_after_accept", erro, (e == 1 || e == 2) ? e : 0);
        chk("fator_out", fator_out, fator);

        busy_c = 0; we_c = 0; rel_c = 0; arm_c = 0; bad_rst = 0; bad_mux = 0; fim = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cmd_ready) begin fim = 1; break; end
            busy_c += int'(busy);
            we_c   += int'(mem_we);
            if (eng_rst_n === oh) begin
                rel_idx = rel_c;
                rel_c++;
                if (mem_rom_addr !== {3'(op), scnt[op]} ||
                    mem_wraddr   !== {3'(op), ~scnt[op]} ||
                    mem_wrdata   !== (scnt[op][7:0] ^ 8'(op*37 + 1)) ||
                    mem_we       !== 1'b1)
                    bad_mux++;
                cmd_abort = (ab >= 0 && rel_idx == ab);
            end else begin
                if (eng_rst_n !== 4'b0000) bad_rst++;
                if (mem_we !== 1'b0 || mem_rom_addr !== '0) bad_mux++;
                if (busy) arm_c++;
                cmd_abort = (ab < 0 && arm_c == 1);
            end
            @(negedge clk);
        end
        cmd_abort = 1'b0;

        chk("cmd_finished", fim, 1);
        chk("busy_cycles", busy_c, exp_arm + run_len + drain);
        chk("arm_cycles", arm_c, exp_arm);
        chk("released_cycles", rel_c, run_len + drain);
        chk("we_cycles", we_c, run_len + drain);
        chk("bad_rst_cycles", bad_rst, 0);
        chk("bad_mux_cycles", bad_mux, 0);
        chk("erro_final", erro, e);
        chk("done_final", done, (e == 0));
        chk("rst_final", eng_rst_n, 4'b0000);
        chk("we_final", mem_we, 0);
    endtask

    task automatic abort_idle(input logic [2:0] erro_exp, input logic done_exp);
        cmd_abort = 1'b1;
        repeat (3) @(negedge clk);
        cmd_abort = 1'b0;
        chk("abort_idle_ready", cmd_ready, 1);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_erro", erro, erro_exp);
        chk("abort_idle_done", done, done_exp);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_eng", eng_rst_n, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_erro", erro, 0);
        chk("rst_fator", fator_out, 0);
        chk("rst_mem", {mem_we, mem_wrdata, mem_rom_addr}, 0);
        reset = 1'b1;
        @(negedge clk);

        run_cmd(0, 2, 99, NO_AB);       // done after 100 RUN cycles
        abort_idle(3'd0, 1'b1);         // abort in FIM ignored
        run_cmd(1, 3, 10, NO_AB);       // illegal factor
        run_cmd(3, 4, 10, NO_AB);       // unpopulated slot
        run_cmd(0, 0, 10, NO_AB);       // factor 0
        run_cmd(1, 2, 5000, NO_AB);     // timeout
        run_cmd(2, 4, 50, NO_AB);       // new command clears erro
        run_cmd(0, 4, 100, 10);         // abort in RUN
        run_cmd(1, 2, 50, -1);          // abort in ARM
        run_cmd(0, 2, 30, 31);          // abort during DRAIN ignored
        run_cmd(1, 4, 40, 40);          // abort and done together: abort wins
        run_cmd(2, 2, TMO - 1, NO_AB);  // done on last cycle beats timeout

        // reset mid-RUN
        for (int i = 0; i < 4; i++) dat[i] = 0;
        dat[0] = 5000;
        cmd_op = 2'd0; cmd_fator = 3'd2; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_released", eng_rst_n, 4'b0001);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_ready", cmd_ready, 1);
        chk("async_rst_eng", eng_rst_n, 4'b0000);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fator", fator_out, 0);
        chk("async_rst_mem", {mem_we, mem_wrdata, mem_wraddr, mem_rom_addr}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        abort_idle(3'd0, 1'b0);         // abort in IDLE ignored
        run_cmd(2, 4, 60, NO_AB);

        for (int k = 0; k < 30; k++) begin
            int op, fa, d, ab, r;
            op = $urandom_range(0, 3);
            fa = $urandom_range(0, 7);
            d  = $urandom_range(1, 150);
            r  = $urandom_range(0, 9);
            ab = (r < 3) ? $urandom_range(0, 150) : (r == 3) ? -1 : NO_AB;
            run_cmd(op, fa, d, ab);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_escala.md
Name: controle_escala

Overview:
- Command sequencer for the downscaling engines (block average, nearest-neighbour, etc.) in the coprocessor ULA.
- Accepts one command at a time from the HPS-facing bridge and validates the opcode and scale factor.
- Selects one of 4 engine slots, holds the other slots in reset, releases the selected engine, and muxes its ROM-read and RAM-write buses onto the shared frame memories.
- Detects completion, timeout or abort, parks the engine in reset again, and reports status.

Parameters:
- ENG_MASK, 4'b1111, bit i = engine slot i populated; an op targeting an unpopulated slot is rejected.
- FATOR_OK, 8'b0001_0100, bit f = scale factor f legal (default: 2 and 4).
- SETUP_CYC, 2, cycles engines stay in reset with fator stable before release (min 1).
- TIMEOUT, 200000, max RUN cycles before timeout error.
- AW, 19, memory address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  engine slot index
- cmd_fator  in  3  scale factor
- cmd_abort  in  1  abort request, level, sampled every cycle
- fator_out  out  3  latched factor, driven to all engines
- eng_rst_n  out  4  per-slot active-low engine reset
- eng_rom_addr  in  4*AW  slot i at [i*AW +: AW]
- eng_wraddr  in  4*AW  per-slot RAM write address
- eng_pixel  in  4*8  per-slot output pixel
- eng_done  in  4  per-slot done
- mem_rom_addr  out  AW  shared source ROM address
- mem_wraddr  out  AW  shared destination RAM address
- mem_wrdata  out  8  destination pixel
- mem_we  out  1  destination write enable
- busy  out  1  high in ARM/RUN/DRAIN
- done  out  1  sticky, last command completed OK
- erro  out  3  0 none, 1 bad op, 2 bad fator, 3 timeout, 4 abort

Behaviour:
- Reset values: state IDLE; cmd_ready=1, fator_out=0, eng_rst_n=4'b0000, mem_*=0, mem_we=0, busy=0, done=0, erro=0. Reset is asynchronous and may assert in any state.
- States: IDLE, ARM, RUN, DRAIN, FIM, ERRO. cmd_ready=1 only in IDLE, FIM and ERRO.
- Accept in IDLE/FIM/ERRO:
  - Clear done and erro.
  - Latch op and fator into sel and fator_out.
  - If !ENG_MASK[op]: erro=1, go to ERRO.
  - Else if fator==0 or !FATOR_OK[fator]: erro=2, go to ERRO.
  - Else go to ARM with counter=0.
- ARM: eng_rst_n=0. Stay SETUP_CYC cycles, then go to RUN.
- RUN:
  - eng_rst_n = one-hot(sel); the other slots stay 0.
  - mem_rom_addr = eng_rom_addr[sel]. This mux is combinational in RUN and DRAIN, 0 otherwise.
  - mem_wraddr/mem_wrdata = slot sel's registered outputs; mem_we=1 continuously (engine holds addr/data stable between writes, so rewrites are harmless).
  - Counter increments every cycle.
- RUN exit priority, highest first:
  1. cmd_abort: erro=4, go to ERRO.
  2. eng_done[sel]: go to DRAIN.
  3. counter==TIMEOUT-1: erro=3, go to ERRO.
- DRAIN: exactly 1 cycle, mem_we=1 so the final pixel, registered with done, lands. Slot stays released. Then go to FIM.
- FIM: done=1, eng_rst_n=0 (stops the free-running engine), mem_we=0.
- ERRO: eng_rst_n=0, mem_we=0, erro holds its code.
- Abort in ARM goes to ERRO with erro=4. Abort in IDLE/FIM/ERRO is ignored.
- A cmd_valid during busy is not accepted and must be held by the source.
- eng_done from unselected slots is ignored. An eng_done[sel] already high on release (stale) is not possible because the engine was held in reset.

Test Plan:
- op=0, fator=2, stub engine asserts done after 100 cycles -> cmd_ready low 1 cycle after accept; eng_rst_n=0001 after 2 ARM cycles; mem_we high 101 cycles including DRAIN; done=1, erro=0, eng_rst_n=0000.
- op=1, fator=3 -> erro=2 the cycle after accept; eng_rst_n never leaves 0; cmd_ready=1.
- ENG_MASK=4'b0011, op=3, fator=4 -> erro=1; no engine released.
- TIMEOUT=50, engine never done -> erro=3 exactly 50 RUN cycles after release; eng_rst_n=0000; then a new valid command is accepted and clears erro.
- cmd_abort pulsed in RUN at cycle 10 -> next cycle erro=4, mem_we=0; cmd_abort in IDLE -> no effect.
- reset pulled low mid-RUN -> all outputs at reset values immediately (async); after release, a fator=4 command on slot 2 runs normally, and mem_rom_addr tracks slot 2 only.
